// File: rtl/psi_sorted_scan_pkg.sv
// Shared definitions for the PSI sorted-array scanner: FSM encoding and index sizing.
package psi_sorted_scan_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // One spare bit so idx+2 past the last pair cannot wrap.
    function automatic int idx_width(input int k);
        return $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/psi_elem_select.sv
// Combinational read of the adjacent pair elem[idx], elem[idx+1] from the packed array.
module psi_elem_select
    import psi_sorted_scan_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int K    = 16,
    localparam int IDXW = idx_width(K)
) (
    input  logic [W*K-1:0]  arr_i,
    input  logic [IDXW-1:0] idx_i,
    output logic [W-1:0]    elem_a_o,
    output logic [W-1:0]    elem_b_o
);

    logic [IDXW-1:0] idx_nxt;

    assign idx_nxt = (idx_i >= IDXW'(K - 1)) ? IDXW'(K - 1) : idx_i + IDXW'(1);

    always_comb begin
        elem_a_o = '0;
        elem_b_o = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_i == IDXW'(i))   elem_a_o = arr_i[i*W +: W];
            if (idx_nxt == IDXW'(i)) elem_b_o = arr_i[i*W +: W];
        end
    end

endmodule

// File: rtl/psi_sorted_scan.sv
// Scans a sorted array for equal adjacent pairs and streams each intersection value out.
//
// state    | meaning
// ST_IDLE  | in_ready high; waiting for an array
// ST_SCAN  | evaluating one adjacent pair per step, emitting matches
// ST_FLUSH | waiting for the last match to drain, then pulse done
module psi_sorted_scan
    import psi_sorted_scan_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int K    = 16,
    localparam int IDXW = idx_width(K)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W*K-1:0]   in_array_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_data_o,
    output logic [IDXW-1:0]  match_cnt_o,
    output logic             done_o
);

    state_t          state_q, state_d;
    logic [W*K-1:0]  arr_q, arr_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            done_q, done_d;

    logic [W-1:0]    elem_a, elem_b;
    logic [IDXW-1:0] idx_step;
    logic            step;

    psi_elem_select #(.W(W), .K(K)) u_sel (
        .arr_i    (arr_q),
        .idx_i    (idx_q),
        .elem_a_o (elem_a),
        .elem_b_o (elem_b)
    );

    assign step = !out_valid_q || out_ready_i;

    always_comb begin
        state_d     = state_q;
        arr_d       = arr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        idx_step    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    arr_d   = in_array_i;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (step) begin
                    if (elem_a == elem_b) begin
                        out_data_d  = elem_a;
                        out_valid_d = 1'b1;
                        cnt_d       = cnt_q + IDXW'(1);
                        idx_step    = idx_q + IDXW'(2);
                    end else begin
                        out_valid_d = 1'b0;
                        idx_step    = idx_q + IDXW'(1);
                    end
                    idx_d = idx_step;
                    // No pair left once the new idx has no successor element.
                    if (idx_step >= IDXW'(K - 1)) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (step) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            arr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arr_q       <= arr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign match_cnt_o = cnt_q;
    assign done_o      = done_q;

endmodule
